// File: rtl/serial_feeder_pkg.sv
// Shared types and constants for serial_word_feeder and its holding buffer.
package serial_feeder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width for a WIDTH-bit word; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_feeder_skid.sv
// One-entry holding buffer for serial_word_feeder; compiled only when
// SERIAL_FEEDER_SKID_EN is defined.
`ifdef SERIAL_FEEDER_SKID_EN
module serial_feeder_skid
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic [WIDTH-1:0] pop_data
);

    logic [WIDTH-1:0] word;

    // A push in the same cycle as a pop refills the entry, so push wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload register has no reset; it is only ever read while
    // full is set, so resetting it would cost logic and buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            word <= push_data;
        end
    end

    assign pop_data = word;

endmodule
`endif

// File: rtl/serial_word_feeder.sv
// Parallel-in/serial-out feeder for the sequence detector. Define
// SERIAL_FEEDER_SKID_EN to add a one-entry holding buffer for gap-free streams.
module serial_word_feeder
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data,
    output logic             data_valid,
    output logic             word_done
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg, sreg_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             data_nx, data_valid_nx, word_done_nx;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_word;

    assign accept = in_valid && in_ready;

`ifdef SERIAL_FEEDER_SKID_EN
    logic             buf_full;
    logic             buf_push;
    logic             buf_pop;
    logic [WIDTH-1:0] buf_data;

    assign in_ready  = rst && !buf_full;
    // Words arriving while a word is shifting are parked; the buffer always
    // feeds the shift register ahead of the input so order is preserved.
    assign buf_push  = accept && (state == SHIFT);
    assign load      = ((state == IDLE) && (buf_full || accept)) ||
                       ((state == SHIFT) && (cnt == LAST) && buf_full);
    assign buf_pop   = load && buf_full;
    assign load_word = buf_full ? buf_data : in_data;

    serial_feeder_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (buf_push),
        .push_data(in_data),
        .pop      (buf_pop),
        .full     (buf_full),
        .pop_data (buf_data)
    );
`else
    assign in_ready  = rst && (state == IDLE);
    assign load      = accept;
    assign load_word = in_data;
`endif

    // NOTE: combinational blocks use blocking '=' and start with a default for
    // every output so no path leaves a signal unassigned (no inferred latch).
    always_comb begin
        state_nx      = state;
        sreg_nx       = sreg;
        cnt_nx        = cnt;
        data_nx       = 1'b0;
        data_valid_nx = 1'b0;
        word_done_nx  = 1'b0;

        if (load) begin
            state_nx      = SHIFT;
            data_nx       = MSB_FIRST ? load_word[WIDTH-1] : load_word[0];
            sreg_nx       = MSB_FIRST ? (load_word << 1) : (load_word >> 1);
            cnt_nx        = '0;
            data_valid_nx = 1'b1;
        end else if ((state == SHIFT) && (cnt != LAST)) begin
            data_nx       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
            sreg_nx       = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            cnt_nx        = cnt + CW'(1);
            data_valid_nx = 1'b1;
            word_done_nx  = (cnt_nx == LAST);
        end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end
    end

    // NOTE: state is updated with non-blocking '<=' so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            data       <= 1'b0;
            data_valid <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            sreg       <= sreg_nx;
            cnt        <= cnt_nx;
            data       <= data_nx;
            data_valid <= data_valid_nx;
            word_done  <= word_done_nx;
        end
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Self-checking bench for serial_word_feeder: MSB-first and LSB-first
// instances share stimulus and are checked against a bit-stream model.
module tb_serial_word_feeder;

    localparam int W = 8;
`ifdef SERIAL_FEEDER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         in_valid = 1'b0;
    logic         in_ready_m, data_m, dv_m, wd_m;
    logic         in_ready_l, data_l, dv_l, wd_l;

    always #5 clk = ~clk;

    serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .data(data_m), .data_valid(dv_m), .word_done(wd_m)
    );

    serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .data(data_l), .data_valid(dv_l), .word_done(wd_l)
    );

    int           errors = 0;
    int           checks = 0;
    int           cyc    = 0;
    int           stray  = 0;
    logic         accepted;
    logic [W-1:0] acc_words[$];
    int           acc_cyc[$];
    int           dv_cyc[$];
    logic         bits_m[$], bits_l[$], wdq_m[$], wdq_l[$];
    logic         exp_m[$], exp_l[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // One clock: sample outputs/handshake at negedge, return 1 after posedge.
    task automatic step();
        @(negedge clk);
        accepted = rst && in_valid && in_ready_m;
        if (accepted) begin
            acc_words.push_back(in_data);
            acc_cyc.push_back(cyc);
        end
        if (dv_m) begin
            bits_m.push_back(data_m);
            wdq_m.push_back(wd_m);
            dv_cyc.push_back(cyc);
        end else if (data_m || wd_m) begin
            stray++;
        end
        if (dv_l) begin
            bits_l.push_back(data_l);
            wdq_l.push_back(wd_l);
        end else if (data_l || wd_l) begin
            stray++;
        end
        if (dv_m !== dv_l || in_ready_m !== in_ready_l) stray++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_log();
        acc_words.delete(); acc_cyc.delete(); dv_cyc.delete();
        bits_m.delete(); bits_l.delete(); wdq_m.delete(); wdq_l.delete();
        stray = 0;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    // Present w until accepted; with jitter, in_data changes while stalled
    // and right after acceptance (illegal upstream behaviour).
    task automatic send_word(input logic [W-1:0] w, input bit jitter);
        int n;
        n = 0;
        in_data  = w;
        in_valid = 1'b1;
        do begin
            step();
            n++;
            if (!accepted && jitter) in_data = W'($urandom);
        end while (!accepted && n < 100);
        if (jitter) in_data = W'($urandom);
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL send_word: word %h not accepted after %0d cycles, required within 100", w, n);
        end
    endtask

    // Reference: every accepted word contributes W bits, in order, in the
    // instance's bit order.
    function automatic void build_model();
        exp_m.delete();
        exp_l.delete();
        foreach (acc_words[k]) begin
            for (int b = 0; b < W; b++) begin
                exp_m.push_back(acc_words[k][W-1-b]);
                exp_l.push_back(acc_words[k][b]);
            end
        end
    endfunction

    function automatic int stream_diffs();
        int n;
        n = 0;
        if (bits_m.size() != exp_m.size()) n++;
        if (bits_l.size() != exp_l.size()) n++;
        for (int i = 0; i < bits_m.size() && i < exp_m.size(); i++)
            if (bits_m[i] !== exp_m[i]) n++;
        for (int i = 0; i < bits_l.size() && i < exp_l.size(); i++)
            if (bits_l[i] !== exp_l[i]) n++;
        return n;
    endfunction

    function automatic int done_diffs();
        int n;
        n = 0;
        for (int i = 0; i < wdq_m.size(); i++)
            if (wdq_m[i] !== ((i % W) == (W - 1))) n++;
        for (int i = 0; i < wdq_l.size(); i++)
            if (wdq_l[i] !== ((i % W) == (W - 1))) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        step();
        step();
        checks++;
        if ({dv_m, data_m, wd_m, dv_l, data_l, wd_l} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got dv/d/wd=%b%b%b %b%b%b, expected all 0",
                     dv_m, data_m, wd_m, dv_l, data_l, wd_l);
        end
        checks++;
        if (in_ready_m !== 1'b0 || in_ready_l !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b, expected 0 while rst=0", in_ready_m, in_ready_l);
        end
        checks++;
        if (acc_words.size() != 0) begin
            errors++;
            $display("FAIL reset_accept: got %0d accepts, expected 0", acc_words.size());
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready_m !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, expected 1", in_ready_m);
        end
        step();
    endtask

    task automatic test_single_word(input logic [W-1:0] w, input string tag);
        int first, last;
        clear_log();
        send_word(w, 1'b0);
        drain(12);
        build_model();
        first = (dv_cyc.size() > 0) ? dv_cyc[0] : -1;
        last  = (dv_cyc.size() > 0) ? dv_cyc[dv_cyc.size()-1] : -1;
        checks++;
        if (stream_diffs() != 0) begin
            errors++;
            $display("FAIL %s_bits: %0d bit differences (got %0d msb/%0d lsb bits), expected 0",
                     tag, stream_diffs(), bits_m.size(), bits_l.size());
        end
        checks++;
        if (done_diffs() != 0 || wdq_m.size() != W) begin
            errors++;
            $display("FAIL %s_word_done: %0d misplaced pulses over %0d bits, expected 0 over %0d",
                     tag, done_diffs(), wdq_m.size(), W);
        end
        checks++;
        if (first != acc_cyc[0] + 1 || last != acc_cyc[0] + W) begin
            errors++;
            $display("FAIL %s_latency: bits in cycles %0d..%0d, expected %0d..%0d",
                     tag, first, last, acc_cyc[0] + 1, acc_cyc[0] + W);
        end
        checks++;
        if (stray != 0 || in_ready_m !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle: stray=%0d ready=%b, expected stray=0 ready=1",
                     tag, stray, in_ready_m);
        end
    endtask

    task automatic test_back_to_back();
        int span;
        clear_log();
        send_word(8'hA5, 1'b0);
        send_word(8'h5A, 1'b0);
        drain(20);
        build_model();
        span = (dv_cyc.size() > 0) ? dv_cyc[dv_cyc.size()-1] - dv_cyc[0] + 1 : 0;
        checks++;
        if (stream_diffs() != 0 || done_diffs() != 0) begin
            errors++;
            $display("FAIL b2b_stream: %0d bit / %0d word_done differences, expected 0",
                     stream_diffs(), done_diffs());
        end
        checks++;
        if (dv_cyc.size() != 2 * W || span != (SKID ? 2 * W : 2 * W + 1)) begin
            errors++;
            $display("FAIL b2b_timing: got %0d valid bits over %0d cycles, expected %0d over %0d",
                     dv_cyc.size(), span, 2 * W, SKID ? 2 * W : 2 * W + 1);
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL b2b_stray: got %0d stray cycles, expected 0", stray);
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        for (int k = 0; k < 6; k++) send_word(W'($urandom), 1'b1);
        drain(30);
        build_model();
        checks++;
        if (acc_words.size() != 6) begin
            errors++;
            $display("FAIL bp_accepts: got %0d accepted words, expected 6", acc_words.size());
        end
        checks++;
        if (stream_diffs() != 0 || done_diffs() != 0) begin
            errors++;
            $display("FAIL bp_stream: %0d bit / %0d word_done differences, expected 0",
                     stream_diffs(), done_diffs());
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL bp_stray: got %0d stray cycles, expected 0", stray);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        int ones;
        clear_log();
        send_word(8'hFF, 1'b0);
        if (SKID) send_word(8'h0F, 1'b0);
        in_valid = 1'b0;
        n = 0;
        while (bits_m.size() < 3 && n < 50) begin
            step();
            n++;
        end
        rst = 1'b0;
        step();
        checks++;
        if ({dv_m, data_m, dv_l, data_l} !== 4'b0 || in_ready_m !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got dv=%b d=%b ready=%b, expected 0 0 0",
                     dv_m, data_m, in_ready_m);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready_m !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: got %b after release, expected 1", in_ready_m);
        end
        drain(20);
        ones = 0;
        foreach (bits_m[i]) if (bits_m[i] === 1'b1) ones++;
        checks++;
        if (bits_m.size() != 4 || ones != 4 || bits_l.size() != 4) begin
            errors++;
            $display("FAIL midrst_resume: got %0d bits (%0d ones), expected 4 bits of 1 and nothing after",
                     bits_m.size(), ones);
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL midrst_stray: got %0d stray cycles, expected 0", stray);
        end
    endtask

    task automatic test_wrap();
        int dones;
        clear_log();
        for (int k = 0; k < 300; k++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 1)) step();
            send_word(W'($urandom), 1'b0);
        end
        drain(20);
        build_model();
        dones = 0;
        foreach (wdq_m[i]) if (wdq_m[i] === 1'b1) dones++;
        checks++;
        if (dones != 300 || acc_words.size() != 300) begin
            errors++;
            $display("FAIL wrap_done_count: got %0d pulses for %0d words, expected 300 for 300",
                     dones, acc_words.size());
        end
        checks++;
        if (stream_diffs() != 0 || done_diffs() != 0) begin
            errors++;
            $display("FAIL wrap_stream: %0d bit / %0d word_done differences, expected 0",
                     stream_diffs(), done_diffs());
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL wrap_stray: got %0d stray cycles, expected 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_single_word(8'hAA, "msb_first");
        test_single_word(8'h01, "lsb_first");
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
